cam_pingpong_ctrl: RTL
======================

CAM_PINGPONG_CTRL -- requirements
Module: cam_pingpong_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 17: per-bank pixel address width.
REQ-002 SHALL have parameter PIX_W, default 24: pixel data width.
REQ-003 SHALL have parameter FRAME_PIXELS, default 76800: accepted writes per complete frame; legal range is 1 to 2^ADDR_W.
REQ-004 SHALL have parameter CNT_W, default 16: frame_count width.
REQ-005 SHALL have port clk, input, 1: single clock; all other inputs are synchronous to it.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port mode_sel, input, 2: 0 = normal, 1 = processed, 2 = freeze, 3 = treated as normal.
REQ-008 SHALL have port cam_vsync, input, 1: camera vertical sync.
REQ-009 SHALL have port vga_vsync, input, 1: display vertical sync.
REQ-010 SHALL have ports cap_we, cap_addr and cap_data, inputs, widths 1 / ADDR_W / PIX_W: raw capture stream.
REQ-011 SHALL have ports proc_we, proc_addr and proc_data, inputs, widths 1 / ADDR_W / PIX_W: processed (NN) stream.
REQ-012 SHALL have port rd_addr_in, input, ADDR_W: display read address from the address generator.
REQ-013 SHALL have port buf_we, output, 1: frame buffer write enable.
REQ-014 SHALL have port buf_wr_addr, output, ADDR_W+1: write address; the MSB is the bank select.
REQ-015 SHALL have port buf_wr_data, output, PIX_W: write data.
REQ-016 SHALL have port buf_rd_addr, output, ADDR_W+1: read address; the MSB is the bank select.
REQ-017 SHALL have port mode_active, output, 2: mode currently in effect.
REQ-018 SHALL have port frame_count, output, CNT_W: number of bank swaps performed.
REQ-019 SHALL have port frame_drop, output, 1: one-cycle pulse when a frame is discarded.
REQ-020 SHALL have port err_addr, output, 1: sticky out-of-range write flag.

Function
REQ-021 SHALL register cam_vsync and vga_vsync once; a rising edge is current=1 while the registered value=0.
REQ-022 SHALL load mode_sel into mode_active only on a cam_vsync rising edge, mapping the value 3 to 0.
REQ-023 SHALL select the write source from mode_active: 0 = cap_*, 1 = proc_*, 2 = no source.
REQ-024 SHALL register the write path with 1-cycle latency: buf_we, buf_wr_addr = {wr_bank, src_addr}, buf_wr_data.
REQ-025 SHALL accept a write only in CAPTURE state, with source we=1 and src_addr < FRAME_PIXELS.
REQ-026 SHALL, for a write with we=1 and src_addr >= FRAME_PIXELS, suppress the write and set err_addr until reset.
REQ-027 SHALL count accepted writes in pix_cnt, clear it on every cam_vsync rising edge, and saturate it at FRAME_PIXELS.
REQ-028 SHALL drive buf_rd_addr = {rd_bank, rd_addr_in} with 1-cycle latency, in every state.
REQ-029 SHALL implement FSM states SYNC, CAPTURE, WAIT_SWAP and FROZEN.
REQ-030 SHALL, in SYNC, go to CAPTURE on a cam_vsync rise, or to FROZEN if the new mode_active=2.
REQ-031 SHALL, in CAPTURE on a cam_vsync rise with pix_cnt==FRAME_PIXELS, go to WAIT_SWAP.
REQ-032 SHALL, in CAPTURE on a cam_vsync rise with pix_cnt!=FRAME_PIXELS, pulse frame_drop and stay in CAPTURE on the same bank.
REQ-033 SHALL, in WAIT_SWAP, suppress all writes, and on each cam_vsync rise without a concurrent vga_vsync rise, pulse frame_drop.
REQ-034 SHALL, in WAIT_SWAP on a vga_vsync rise, swap the banks: rd_bank<=wr_bank, wr_bank<=~wr_bank, frame_count+1 with wrap; then go to SYNC.
REQ-035 SHALL, on simultaneous cam_vsync and vga_vsync rises in WAIT_SWAP, perform the swap with no frame_drop and go directly to CAPTURE.
REQ-036 SHALL never swap on a vga_vsync rise outside WAIT_SWAP, including a rise coincident with the CAPTURE-to-WAIT_SWAP transition.
REQ-037 SHALL, on any cam_vsync rise where the new mode_active=2, go to FROZEN from any state, discard any pending swap, and not pulse frame_drop.
REQ-038 SHALL, in FROZEN, hold rd_bank, suppress writes, and go to CAPTURE on a cam_vsync rise where the new mode_active!=2.

Reset
REQ-039 SHALL, while rst=1, immediately force: state=SYNC, wr_bank=1, rd_bank=0, mode_active=0, pix_cnt=0, frame_count=0, buf_we=0, buf_wr_addr=0, buf_wr_data=0, buf_rd_addr=0, frame_drop=0, err_addr=0, and both vsync registers=0.
REQ-040 SHALL, when rst asserts mid-frame, abandon the frame; after release no swap occurs until a full frame completes.

Verification (FRAME_PIXELS=16, ADDR_W=5)
REQ-041 Reset, cam rise, 16 cap writes at addr 0-15, cam rise, vga rise -> buf_we at bank-1 addrs 0-15; after the vga rise rd_bank=1, wr_bank=0, frame_count=1.
REQ-042 10 writes, then cam rise -> frame_drop pulses once; rd_bank stays 0; frame_count=0.
REQ-043 Complete frame, then two cam rises before any vga rise -> two frame_drop pulses; the swap occurs on the next vga rise.
REQ-044 In WAIT_SWAP, cam and vga rises on the same cycle -> swap, frame_count+1, no frame_drop, state=CAPTURE.
REQ-045 Write with addr=20 -> buf_we stays 0 and err_addr=1; err_addr persists until rst.
REQ-046 mode_sel=2 at a cam rise -> no buf_we and rd_bank held; mode_sel=1 at a later cam rise -> proc_data appears on buf_wr_data 1 cycle after proc_we.

Source files
------------

// File: rtl/cam_pingpong_ctrl.sv
// ============================================================================
// cam_pingpong_ctrl : ping-pong frame buffer controller for camera capture
//                     and display, swapping banks only on complete frames.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cam_pingpong_ctrl #(
  parameter int ADDR_W       = 17,
  parameter int PIX_W        = 24,
  parameter int FRAME_PIXELS = 76800,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_sel,
  input  logic              cam_vsync,
  input  logic              vga_vsync,
  input  logic              cap_we,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [PIX_W-1:0]  cap_data,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [PIX_W-1:0]  proc_data,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic              buf_we,
  output logic [ADDR_W:0]   buf_wr_addr,
  output logic [PIX_W-1:0]  buf_wr_data,
  output logic [ADDR_W:0]   buf_rd_addr,
  output logic [1:0]        mode_active,
  output logic [CNT_W-1:0]  frame_count,
  output logic              frame_drop,
  output logic              err_addr
);

  localparam logic [ADDR_W:0] c_frame_pix = (ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [1:0]      c_mode_norm = 2'd0;
  localparam logic [1:0]      c_mode_proc = 2'd1;
  localparam logic [1:0]      c_mode_frz  = 2'd2;

  typedef enum logic [1:0] {SYNC, CAPTURE, WAIT_SWAP, FROZEN} state_t;

  state_t             r_state;
  logic               r_cam_vs, r_vga_vs;
  logic               r_wr_bank, r_rd_bank;
  logic [1:0]         r_mode;
  logic [ADDR_W:0]    r_pix_cnt;
  logic [CNT_W-1:0]   r_frame_count;
  logic               r_frame_drop, r_err_addr;
  logic               r_buf_we;
  logic [ADDR_W:0]    r_buf_wr_addr, r_buf_rd_addr;
  logic [PIX_W-1:0]   r_buf_wr_data;

  logic               w_cam_rise, w_vga_rise;
  logic [1:0]         w_mode_new;
  logic               w_src_we, w_in_range, w_accept;
  logic [ADDR_W-1:0]  w_src_addr;
  logic [PIX_W-1:0]   w_src_data;

  assign w_cam_rise = cam_vsync & ~r_cam_vs;
  assign w_vga_rise = vga_vsync & ~r_vga_vs;
  assign w_mode_new = (mode_sel == 2'd3) ? c_mode_norm : mode_sel;

  always_comb begin
    w_src_we   = 1'b0;
    w_src_addr = '0;
    w_src_data = '0;
    case (r_mode)
      c_mode_norm: begin
        w_src_we   = cap_we;
        w_src_addr = cap_addr;
        w_src_data = cap_data;
      end
      c_mode_proc: begin
        w_src_we   = proc_we;
        w_src_addr = proc_addr;
        w_src_data = proc_data;
      end
      default: ;
    endcase
  end

  assign w_in_range = {1'b0, w_src_addr} < c_frame_pix;
  assign w_accept   = (r_state == CAPTURE) && w_src_we && w_in_range;

  // Write/read datapath, pixel counter and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cam_vs      <= 1'b0;
      r_vga_vs      <= 1'b0;
      r_pix_cnt     <= '0;
      r_err_addr    <= 1'b0;
      r_buf_we      <= 1'b0;
      r_buf_wr_addr <= '0;
      r_buf_wr_data <= '0;
      r_buf_rd_addr <= '0;
    end else begin
      r_cam_vs      <= cam_vsync;
      r_vga_vs      <= vga_vsync;
      r_buf_we      <= w_accept;
      r_buf_rd_addr <= {r_rd_bank, rd_addr_in};
      if (w_accept) begin
        r_buf_wr_addr <= {r_wr_bank, w_src_addr};
        r_buf_wr_data <= w_src_data;
      end
      if (w_src_we && !w_in_range)
        r_err_addr <= 1'b1;
      if (w_cam_rise)
        r_pix_cnt <= '0;
      else if (w_accept && r_pix_cnt != c_frame_pix)
        r_pix_cnt <= r_pix_cnt + (ADDR_W+1)'(1);
    end
  end

  // Frame-level FSM: a freeze request at a camera vsync overrides everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= SYNC;
      r_wr_bank     <= 1'b1;
      r_rd_bank     <= 1'b0;
      r_mode        <= c_mode_norm;
      r_frame_count <= '0;
      r_frame_drop  <= 1'b0;
    end else begin
      r_frame_drop <= 1'b0;
      if (w_cam_rise)
        r_mode <= w_mode_new;
      if (w_cam_rise && w_mode_new == c_mode_frz) begin
        r_state <= FROZEN;
      end else begin
        case (r_state)
          SYNC: begin
            if (w_cam_rise)
              r_state <= CAPTURE;
          end
          CAPTURE: begin
            if (w_cam_rise) begin
              if (r_pix_cnt == c_frame_pix)
                r_state <= WAIT_SWAP;
              else
                r_frame_drop <= 1'b1;
            end
          end
          WAIT_SWAP: begin
            if (w_vga_rise) begin
              r_rd_bank     <= r_wr_bank;
              r_wr_bank     <= ~r_wr_bank;
              r_frame_count <= r_frame_count + CNT_W'(1);
              r_state       <= w_cam_rise ? CAPTURE : SYNC;
            end else if (w_cam_rise) begin
              r_frame_drop <= 1'b1;
            end
          end
          FROZEN: begin
            if (w_cam_rise)
              r_state <= CAPTURE;
          end
          default: r_state <= SYNC;
        endcase
      end
    end
  end

  assign buf_we      = r_buf_we;
  assign buf_wr_addr = r_buf_wr_addr;
  assign buf_wr_data = r_buf_wr_data;
  assign buf_rd_addr = r_buf_rd_addr;
  assign mode_active = r_mode;
  assign frame_count = r_frame_count;
  assign frame_drop  = r_frame_drop;
  assign err_addr    = r_err_addr;

endmodule

`default_nettype wire
